ex_mem_latch: RTL

EX_MEM_LATCH -- requirements
Module: ex_mem_latch

---
 rtl/ex_mem_latch_pkg.sv | 55 +++++
 rtl/ex_mem_latch_pipe_reg.sv | 23 ++
 rtl/ex_mem_latch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_latch_pkg.sv
// EX/MEM latch shared types and constants.
// Writeback source codes, FSM state, latch bundle.
package ex_mem_pkg;

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [2:0] {
    SRC_MEM    = 3'd0,
    SRC_ALU    = 3'd1,
    SRC_NPC    = 3'd2,
    SRC_SETVAL = 3'd3,
    SRC_SEXT8  = 3'd4,
    SRC_LBI    = 3'd5,
    SRC_BITREV = 3'd6,
    SRC_BAD    = 3'd7
  } wrSrc_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] aluOut;
    logic [15:0] setVal;
    logic [15:0] reg1Data;
    logic [15:0] reg2Data;
    logic [15:0] nextPc;
    logic        memEn;
    logic        memWrt;
    logic        halt;
    logic        regWrt;
    logic [2:0]  regWrtSrc;
    logic [2:0]  regDst;
  } exMem_t;

  function automatic logic [15:0] bitRev16(
    input logic [15:0] v
  );
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sext8(
    input logic [7:0] v
  );
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/ex_mem_latch_pipe_reg.sv
// Single pipeline field register.
// Enable-gated with synchronous reset to a fixed value.
module pipe_reg #(
  parameter int          W      = 16,
  parameter logic [W-1:0] RSTVAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // reset wins, otherwise load only when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RSTVAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with halt freeze,
// forwarding taps, sticky error and retire count.
module ex_mem_latch
  import ex_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        validIn,
  input  logic [15:0] instrIn,
  input  logic [15:0] aluOutIn,
  input  logic [15:0] setValIn,
  input  logic [15:0] reg1DataIn,
  input  logic [15:0] reg2DataIn,
  input  logic [15:0] nextPcIn,
  input  logic        memEnIn,
  input  logic        memWrtIn,
  input  logic        haltIn,
  input  logic        regWrtIn,
  input  logic [2:0]  regWrtSrcIn,
  input  logic [2:0]  regDstIn,
  output logic        validOut,
  output logic [15:0] instrOut,
  output logic [15:0] aluOut,
  output logic [15:0] setVal,
  output logic [15:0] reg1Data,
  output logic [15:0] reg2Data,
  output logic [15:0] nextPc,
  output logic        memEn,
  output logic        memWrt,
  output logic        halt,
  output logic        regWrtOut,
  output logic [2:0]  regWrtSrc,
  output logic [2:0]  regDst,
  output logic        fwdValid,
  output logic [2:0]  fwdReg,
  output logic [15:0] fwdData,
  output logic        loadUse,
  output logic        err,
  output logic [15:0] instCount
);

  state_e state;
  state_e stateNxt;
  logic   halted;
  logic   loadEn;
  logic   bubble;
  logic   realLoad;
  logic   errSet;
  exMem_t inB;
  exMem_t dB;
  wrSrc_e outSrc;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= stateNxt;
    end
  end

  // FSM next state: a real halt load parks the latch
  always_comb begin
    stateNxt = state;
    unique case (state)
      RUN:     if (realLoad && haltIn) stateNxt = HALTED;
      HALTED:  stateNxt = HALTED;
      default: stateNxt = RUN;
    endcase
  end

  // FSM outputs: halted freezes everything
  always_comb begin
    halted = (state == HALTED);
    loadEn = ~halted & ~stall;
  end

  // load classification and sticky error trigger
  always_comb begin
    bubble   = flush | ~validIn;
    realLoad = loadEn & ~bubble;
    errSet   = realLoad & regWrtIn
             & (regWrtSrcIn == SRC_BAD);
  end

  // gather inputs into one bundle
  always_comb begin
    inB           = '0;
    inB.valid     = validIn;
    inB.instr     = instrIn;
    inB.aluOut    = aluOutIn;
    inB.setVal    = setValIn;
    inB.reg1Data  = reg1DataIn;
    inB.reg2Data  = reg2DataIn;
    inB.nextPc    = nextPcIn;
    inB.memEn     = memEnIn;
    inB.memWrt    = memWrtIn;
    inB.halt      = haltIn;
    inB.regWrt    = regWrtIn;
    inB.regWrtSrc = regWrtSrcIn;
    inB.regDst    = regDstIn;
  end

  // substitute a NOP bubble for flushed or empty slots
  always_comb begin
    dB       = '0;
    dB.instr = NOP;
    if (!bubble) begin
      dB = inB;
    end
  end

  pipe_reg #(.W(1)) uValid (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.valid), .q(validOut)
  );

  pipe_reg #(.W(16), .RSTVAL(NOP)) uInstr (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.instr), .q(instrOut)
  );

  pipe_reg #(.W(16)) uAlu (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.aluOut), .q(aluOut)
  );

  pipe_reg #(.W(16)) uSetVal (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.setVal), .q(setVal)
  );

  pipe_reg #(.W(16)) uReg1 (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.reg1Data), .q(reg1Data)
  );

  pipe_reg #(.W(16)) uReg2 (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.reg2Data), .q(reg2Data)
  );

  pipe_reg #(.W(16)) uNextPc (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.nextPc), .q(nextPc)
  );

  pipe_reg #(.W(1)) uMemEn (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.memEn), .q(memEn)
  );

  pipe_reg #(.W(1)) uMemWrt (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.memWrt), .q(memWrt)
  );

  pipe_reg #(.W(1)) uHalt (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.halt), .q(halt)
  );

  pipe_reg #(.W(1)) uRegWrt (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.regWrt), .q(regWrtOut)
  );

  pipe_reg #(.W(3)) uWrSrc (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.regWrtSrc), .q(regWrtSrc)
  );

  pipe_reg #(.W(3)) uRegDst (
    .clk(clk), .rst(rst), .en(loadEn),
    .d(dB.regDst), .q(regDst)
  );

  pipe_reg #(.W(16)) uCount (
    .clk(clk), .rst(rst), .en(realLoad),
    .d(instCount + 16'd1), .q(instCount)
  );

  pipe_reg #(.W(1)) uErr (
    .clk(clk), .rst(rst), .en(errSet),
    .d(1'b1), .q(err)
  );

  // forwarding and load-use flags from the latched slot
  always_comb begin
    outSrc   = wrSrc_e'(regWrtSrc);
    fwdReg   = regDst;
    fwdValid = validOut & regWrtOut
             & (outSrc != SRC_MEM)
             & (outSrc != SRC_BAD);
    loadUse  = validOut & regWrtOut
             & (outSrc == SRC_MEM);
  end

  // forwarded value selected by writeback source
  always_comb begin
    fwdData = '0;
    unique case (1'b1)
      (outSrc == SRC_ALU):
        fwdData = aluOut;
      (outSrc == SRC_NPC):
        fwdData = nextPc;
      (outSrc == SRC_SETVAL):
        fwdData = setVal;
      (outSrc == SRC_SEXT8):
        fwdData = sext8(instrOut[7:0]);
      (outSrc == SRC_LBI):
        fwdData = {reg1Data[7:0], instrOut[7:0]};
      (outSrc == SRC_BITREV):
        fwdData = bitRev16(reg1Data);
      default:
        fwdData = '0;
    endcase
  end

endmodule
